clk_flag_sched: RTL and testbench



---
 rtl/clk_flag_sched_pkg.sv | 15 +
 rtl/clk_flag_div_core.sv | 37 +++
 rtl/clk_flag_sched.sv | 105 ++++++++++
 tb/tb_clk_flag_sched.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_flag_sched_pkg.sv
// rtl/clk_flag_sched_pkg.sv - shared types and constants for the clk_flag scheduler
// Holds the FSM state encoding, minimum divide ratio and default widths.
package clk_flag_sched_pkg;

  localparam int DIV_W_DEF   = 16;
  localparam int BURST_W_DEF = 8;
  localparam int DIV_MIN     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/clk_flag_div_core.sv
// rtl/clk_flag_div_core.sv - divide-by-N counter producing a registered one-cycle flag
// o_wrap is the combinational "this edge wraps" qualifier; o_flag is the registered pulse.
module clk_flag_div_core #(
  parameter int DIV_W = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_wrap,
  output logic             o_flag
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_flag;

  assign o_wrap = i_enable && (r_cnt == (i_div - 1'b1));
  assign o_flag = r_flag;

  // clear wins over enable so an abort never lets a coincident wrap through
  always_ff @(posedge sys_clk) begin
    if (sys_rst || i_clear) begin
      r_cnt  <= '0;
      r_flag <= 1'b0;
    end else if (o_wrap) begin
      r_cnt  <= '0;
      r_flag <= 1'b1;
    end else if (i_enable) begin
      r_cnt  <= r_cnt + 1'b1;
      r_flag <= 1'b0;
    end else begin
      r_flag <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_flag_sched.sv
// rtl/clk_flag_sched.sv - config handshake, run FSM and flag counting around the divide core
// Optional tick gating is enabled by defining CLK_FLAG_SCHED_GATE_EN.
module clk_flag_sched
  import clk_flag_sched_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [DIV_W-1:0]   cfg_div,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic               stop,
`ifdef CLK_FLAG_SCHED_GATE_EN
  input  logic               tick_en,
`endif
  output logic               clk_flag,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] flag_cnt
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DIV_W-1:0]   r_div;
  logic [BURST_W-1:0] r_burst;
  logic [BURST_W-1:0] r_flag_cnt;
  logic [BURST_W-1:0] w_flag_cnt_nxt;
  logic [DIV_W-1:0]   w_div_clamped;
  logic               w_accept;
  logic               w_tick;
  logic               w_enable;
  logic               w_clear;
  logic               w_wrap;
  logic               w_flag_edge;
  logic               w_last;
  logic               w_flag;

`ifdef CLK_FLAG_SCHED_GATE_EN
  assign w_tick = tick_en;
`else
  assign w_tick = 1'b1;
`endif

  assign w_accept       = cfg_valid && (r_state == IDLE);
  assign w_div_clamped  = (cfg_div < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : cfg_div;
  assign w_enable       = (r_state == RUN) && w_tick;
  assign w_clear        = (r_state != RUN) || stop;
  assign w_flag_edge    = w_wrap && !stop;
  assign w_flag_cnt_nxt = r_flag_cnt + 1'b1;
  assign w_last         = w_flag_edge && (r_burst != '0) && (w_flag_cnt_nxt == r_burst);

  clk_flag_div_core #(
    .DIV_W (DIV_W)
  ) u_div_core (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .i_clear  (w_clear),
    .i_enable (w_enable),
    .i_div    (r_div),
    .o_wrap   (w_wrap),
    .o_flag   (w_flag)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (cfg_valid) w_state_nxt = RUN;
      RUN: begin
        if (stop)        w_state_nxt = IDLE;
        else if (w_last) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_div      <= '0;
      r_burst    <= '0;
      r_flag_cnt <= '0;
    end else if (w_accept) begin
      r_div      <= w_div_clamped;
      r_burst    <= cfg_burst;
      r_flag_cnt <= '0;
    end else if (w_flag_edge) begin
      r_flag_cnt <= w_flag_cnt_nxt;
    end
  end

  assign cfg_ready = (r_state == IDLE);
  assign busy      = (r_state == RUN) || (r_state == DONE);
  assign done      = (r_state == DONE);
  assign clk_flag  = w_flag;
  assign flag_cnt  = r_flag_cnt;

endmodule

// File: tb/tb_clk_flag_sched.sv
// tb/tb_clk_flag_sched.sv - scoreboard bench for clk_flag_sched
// Stimulus pushes expected flag events; a negedge monitor pops and compares them.
module tb_clk_flag_sched;

  logic        sys_clk   = 1'b0;
  logic        sys_rst   = 1'b1;
  logic        cfg_valid = 1'b0;
  logic [15:0] cfg_div   = '0;
  logic [7:0]  cfg_burst = '0;
  logic        stop      = 1'b0;
`ifdef CLK_FLAG_SCHED_GATE_EN
  logic        tick_en   = 1'b1;
`endif
  logic        cfg_ready;
  logic        clk_flag;
  logic        busy;
  logic        done;
  logic [7:0]  flag_cnt;

  int total  = 0;
  int bad    = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int cyc;
    bit done;
    int fc;
  } exp_t;

  exp_t q[$];
  exp_t m_e;

  clk_flag_sched dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_burst (cfg_burst),
    .stop      (stop),
`ifdef CLK_FLAG_SCHED_GATE_EN
    .tick_en   (tick_en),
`endif
    .clk_flag  (clk_flag),
    .busy      (busy),
    .done      (done),
    .flag_cnt  (flag_cnt)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at cyc %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input bit d, input int fc);
    exp_t e;
    e.cyc  = c;
    e.done = d;
    e.fc   = fc;
    q.push_back(e);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge sys_clk);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic chk_idle(input string nm, input int fc);
    chk({nm, "_ready"}, cfg_ready, 1);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_fcnt"}, flag_cnt, fc);
  endtask

  // called at a negedge in IDLE; returns at the negedge after the accept edge
  task automatic start(input int div, input int burst, output int acc);
    cfg_valid = 1'b1;
    cfg_div   = 16'(div);
    cfg_burst = 8'(burst);
    acc       = cyc + 1;
    @(negedge sys_clk);
    cfg_valid = 1'b0;
  endtask

  always @(negedge sys_clk) begin
    if (mon_en) begin
      if (clk_flag === 1'b1) begin
        if (q.size() == 0) begin
          chk("flag_unexpected", clk_flag, 0);
        end else begin
          m_e = q.pop_front();
          chk("flag_cyc", cyc, m_e.cyc);
          chk("flag_done", done, m_e.done);
          chk("flag_cnt", flag_cnt, m_e.fc);
        end
      end else begin
        chk("done_alone", done, 0);
      end
    end
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL timeout: got running expected finished at cyc %0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int acc;
    int acc2;

    tick(3);
    chk("rst_outs", {cfg_ready, busy, done, clk_flag, flag_cnt}, {4'b1000, 8'h00});
    mon_en  = 1'b1;
    sys_rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("idle_outs", {cfg_ready, busy, done, clk_flag, flag_cnt}, {4'b1000, 8'h00});
    end

    // burst of 3 at N=6
    start(6, 3, acc);
    push(acc + 6, 0, 1);
    push(acc + 12, 0, 2);
    push(acc + 18, 1, 3);
    chk("b_run_busy", busy, 1);
    chk("b_run_ready", cfg_ready, 0);
    wait_cyc(acc + 18);
    chk("b_done_busy", busy, 1);
    chk("b_done_ready", cfg_ready, 0);
    tick(1);
    chk_idle("b_after", 3);

    // continuous, div=1 clamps to 2, stop on a wrap cycle
    start(1, 0, acc);
    for (int k = 1; k <= 5; k++) push(acc + 2 * k, 0, k);
    wait_cyc(acc + 11);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk_idle("stop", 5);
    chk("stop_flag", clk_flag, 0);
    tick(4);
    chk_idle("stop_hold", 5);

    // config during RUN ignored, accepted after DONE->IDLE
    start(4, 2, acc);
    push(acc + 4, 0, 1);
    push(acc + 8, 1, 2);
    wait_cyc(acc + 2);
    cfg_valid = 1'b1;
    cfg_div   = 16'd3;
    cfg_burst = 8'd1;
    wait_cyc(acc + 9);
    chk_idle("cfg_gap", 2);
    acc2 = acc + 10;
    push(acc2 + 3, 1, 1);
    tick(1);
    cfg_valid = 1'b0;
    chk("cfg_new_busy", busy, 1);
    wait_cyc(acc2 + 4);
    chk_idle("cfg_new", 1);

    // reset mid-burst after two flags
    start(5, 10, acc);
    push(acc + 5, 0, 1);
    push(acc + 10, 0, 2);
    wait_cyc(acc + 11);
    sys_rst = 1'b1;
    tick(1);
    chk("midrst_outs", {cfg_ready, busy, done, clk_flag, flag_cnt}, {4'b1000, 8'h00});
    sys_rst = 1'b0;
    tick(10);
    chk_idle("midrst_after", 0);

`ifdef CLK_FLAG_SCHED_GATE_EN
    // tick_en alternating from the accept cycle: flags every 6 cycles
    start(3, 2, acc);
    push(acc + 5, 0, 1);
    push(acc + 11, 1, 2);
    while (cyc < acc + 12) begin
      tick_en = ((cyc - acc) % 2 == 0);
      @(negedge sys_clk);
    end
    chk_idle("gate_burst", 2);
    tick_en = 1'b0;
    start(3, 0, acc);
    tick(2);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk_idle("gate_stop", 0);
    tick_en = 1'b1;
`endif

    tick(3);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
